// File: rtl/pmem_pkg.sv
// Shared program-memory constants and boot-loader types.
// Used by the loader, program_memory and the CPU fetch stage.
package pmem_pkg;

  localparam int PMEM_ADDR_WIDTH = 10;
  localparam int PMEM_DATA_WIDTH = 16;

  // Header and instruction words arrive most-significant byte first
  localparam bit HDR_BIG_ENDIAN = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    LEN_HI,
    LEN_LO,
    DATA_HI,
    DATA_LO,
    WRITE,
    DONE,
    ERROR
  } ld_state_e;

  function automatic logic [15:0] join_bytes(
    input logic [7:0] first,
    input logic [7:0] second
  );
    if (HDR_BIG_ENDIAN)
      return {first, second};
    else
      return {second, first};
  endfunction

endpackage

// File: rtl/pmem_loader_timeout.sv
// Saturating idle counter for the boot loader.
// tc is high once TIMEOUT_CYCLES-1 idle cycles have been counted.
module pmem_loader_timeout #(
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic clr,
  input  logic inc,
  output logic tc
);

  localparam int CW =
    (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] cnt_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (inc && (cnt_q != LAST)) begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

  assign tc = (cnt_q == LAST);

endmodule

// File: rtl/pmem_loader.sv
// Boot-time program memory loader: length header, then
// big-endian words written from address 0; holds the CPU meanwhile.
module pmem_loader
  import pmem_pkg::*;
#(
  parameter int ADDR_WIDTH     = PMEM_ADDR_WIDTH,
  parameter int DATA_WIDTH     = PMEM_DATA_WIDTH,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_start,
  input  logic [7:0]            i_byte,
  input  logic                  i_byte_valid,
  output logic                  o_pmem_write,
  output logic [ADDR_WIDTH-1:0] o_pmem_address,
  output logic [DATA_WIDTH-1:0] o_pmem_data,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_error,
  output logic                  o_cpu_hold
);

  localparam logic [16:0] MAX_LEN = 17'(2 ** ADDR_WIDTH);

  ld_state_e state_q, state_d;

  logic [15:0]           count_q;
  logic [15:0]           wcnt_q;
  logic [7:0]            hi_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [ADDR_WIDTH-1:0] wr_addr_q;
  logic [DATA_WIDTH-1:0] wr_data_q;

  logic        loading;
  logic        idle_like;
  logic        start_ok;
  logic        accept;
  logic        to_tc;
  logic        timeout;
  logic        len_bad;
  logic        last_word;
  logic [15:0] new_word;

  assign loading = (state_q == LEN_HI) || (state_q == LEN_LO) ||
                   (state_q == DATA_HI) || (state_q == DATA_LO);

  assign idle_like = (state_q == IDLE) || (state_q == DONE) ||
                     (state_q == ERROR);

  assign start_ok  = idle_like && i_start;
  assign accept    = loading && i_byte_valid;
  assign timeout   = loading && !i_byte_valid && to_tc;
  assign new_word  = join_bytes(hi_q, i_byte);
  assign len_bad   = (new_word == 16'd0) ||
                     ({1'b0, new_word} > MAX_LEN);
  assign last_word = ((wcnt_q + 16'd1) == count_q);

  pmem_loader_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .i_clk  (i_clk),
    .i_rst_n(i_rst_n),
    .clr    (!loading || accept),
    .inc    (loading && !i_byte_valid),
    .tc     (to_tc)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE, DONE, ERROR: begin
        if (i_start) state_d = LEN_HI;
      end
      LEN_HI: begin
        if (i_byte_valid) state_d = LEN_LO;
        else if (timeout) state_d = ERROR;
      end
      LEN_LO: begin
        if (i_byte_valid) state_d = len_bad ? ERROR : DATA_HI;
        else if (timeout) state_d = ERROR;
      end
      DATA_HI: begin
        if (i_byte_valid) state_d = DATA_LO;
        else if (timeout) state_d = ERROR;
      end
      DATA_LO: begin
        if (i_byte_valid) state_d = WRITE;
        else if (timeout) state_d = ERROR;
      end
      WRITE: begin
        state_d = last_word ? DONE : DATA_HI;
      end
      default: state_d = IDLE;
    endcase
  end

  // The write port registers are captured with the low byte so they
  // stay stable after the strobe; addr_q already points past them.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      count_q   <= '0;
      wcnt_q    <= '0;
      hi_q      <= '0;
      addr_q    <= '0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      unique case (1'b1)
        start_ok: begin
          count_q <= '0;
          wcnt_q  <= '0;
          addr_q  <= '0;
        end
        accept && (state_q == LEN_HI),
        accept && (state_q == DATA_HI): begin
          hi_q <= i_byte;
        end
        accept && (state_q == LEN_LO): begin
          count_q <= new_word;
        end
        accept && (state_q == DATA_LO): begin
          wr_addr_q <= addr_q;
          wr_data_q <= DATA_WIDTH'(new_word);
        end
        state_q == WRITE: begin
          addr_q <= addr_q + ADDR_WIDTH'(1);
          wcnt_q <= wcnt_q + 16'd1;
        end
        default: ;
      endcase
    end
  end

  assign o_pmem_write   = (state_q == WRITE);
  assign o_pmem_address = wr_addr_q;
  assign o_pmem_data    = wr_data_q;
  assign o_busy         = loading || (state_q == WRITE);
  assign o_done         = (state_q == DONE);
  assign o_error        = (state_q == ERROR);
  assign o_cpu_hold     = (state_q != DONE);

endmodule
